// File: rtl/cdc_handshake_tx_if.sv
// rtl/cdc_handshake_tx_if.sv - local valid/ready and far-side req/ack signals of cdc_handshake_tx
interface cdc_handshake_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  req;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack;
  logic                  busy;
  logic                  timeout_err;

  // master: local producer plus far-side acknowledger; slave: the handshake initiator
  modport master (
    output in_valid, in_data, ack,
    input  in_ready, req, data_out, busy, timeout_err
  );

  modport slave (
    input  in_valid, in_data, ack,
    output in_ready, req, data_out, busy, timeout_err
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// rtl/cdc_handshake_tx.sv - source side of a 4-phase req/ack word transfer into another clock domain
module cdc_handshake_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                rst,
  cdc_handshake_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HIGH = 2'd1,
    ACK_LOW  = 2'd2
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                  ack_s;
  logic                  in_ready;
  logic                  accept;

  // ack is asynchronous; only the last flop of the chain is trusted
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack};
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign in_ready = (state_q == IDLE) && !ack_s && !rst;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = bus.in_data;
          req_d   = 1'b1;
          cnt_d   = 16'd0;
          state_d = REQ_HIGH;
        end
      end
      REQ_HIGH: begin
        // ack beats a timeout landing on the same cycle
        if (ack_s) begin
          req_d   = 1'b0;
          cnt_d   = 16'd0;
          state_d = ACK_LOW;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          cnt_d   = 16'd0;
          state_d = ACK_LOW;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACK_LOW: begin
        // a stuck-high ack flags the error but the FSM still waits for it to fall
        if (!ack_s) begin
          state_d = IDLE;
        end else if (TMO_EN) begin
          if (cnt_q == TMO_LAST) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign bus.in_ready    = in_ready;
  assign bus.req         = req_q;
  assign bus.data_out    = data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb/tb_cdc_handshake_tx.sv - directed self-checking bench for cdc_handshake_tx
module tb_cdc_handshake_tx;
  logic clk = 1'b0;
  logic rst;
  logic loop;
  logic ack_man;
  int   checks = 0;
  int   errors = 0;

  cdc_handshake_tx_if #(.DATA_WIDTH(8)) bus ();

  assign bus.ack = loop ? bus.req : ack_man;

  cdc_handshake_tx #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(3),
    .TIMEOUT    (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one loopback transfer: req high for 4 cycles, in_ready back 8 cycles after accept
  task automatic xfer(input string tag, input logic [7:0] d, input logic exp_err);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    check({tag, " req_after_accept"}, 32'(bus.req), 32'd1);
    check({tag, " data_after_accept"}, 32'(bus.data_out), 32'(d));
    check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    check({tag, " ready_after_accept"}, 32'(bus.in_ready), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("%s req_c%0d", tag, i), 32'(bus.req), (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("%s ready_c%0d", tag, i), 32'(bus.in_ready), (i == 8) ? 32'd1 : 32'd0);
      check($sformatf("%s data_c%0d", tag, i), 32'(bus.data_out), 32'(d));
      check($sformatf("%s err_c%0d", tag, i), 32'(bus.timeout_err), 32'(exp_err));
    end
    check({tag, " busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    loop         = 1'b0;
    ack_man      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ready", 32'(bus.in_ready), 32'd0);
      check("rst_req", 32'(bus.req), 32'd0);
      check("rst_data", 32'(bus.data_out), 32'h00);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_err", 32'(bus.timeout_err), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // single loopback transfer
    loop = 1'b1;
    xfer("single", 8'hA5, 1'b0);

    // back-to-back with in_valid held
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    step();
    check("b2b first_data", 32'(bus.data_out), 32'h11);
    check("b2b first_req", 32'(bus.req), 32'd1);
    bus.in_data = 8'h22;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("b2b hold_data_c%0d", i), 32'(bus.data_out), 32'h11);
      check($sformatf("b2b ready_c%0d", i), 32'(bus.in_ready), (i == 8) ? 32'd1 : 32'd0);
    end
    step();
    bus.in_valid = 1'b0;
    check("b2b second_data", 32'(bus.data_out), 32'h22);
    check("b2b second_req", 32'(bus.req), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("b2b2 data_c%0d", i), 32'(bus.data_out), 32'h22);
      check($sformatf("b2b2 req_c%0d", i), 32'(bus.req), (i < 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b no_dup_busy", 32'(bus.busy), 32'd0);
      check("b2b no_dup_data", 32'(bus.data_out), 32'h22);
    end

    // timeout with ack stuck low
    loop         = 1'b0;
    ack_man      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    step();
    bus.in_valid = 1'b0;
    check("tmo accept_req", 32'(bus.req), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("tmo req_c%0d", i), 32'(bus.req), (i < 10) ? 32'd1 : 32'd0);
      check($sformatf("tmo err_c%0d", i), 32'(bus.timeout_err), (i >= 10) ? 32'd1 : 32'd0);
      check($sformatf("tmo data_c%0d", i), 32'(bus.data_out), 32'h3C);
    end
    step();
    check("tmo idle_busy", 32'(bus.busy), 32'd0);
    check("tmo idle_ready", 32'(bus.in_ready), 32'd1);
    check("tmo err_sticky", 32'(bus.timeout_err), 32'd1);
    loop = 1'b1;
    xfer("after_tmo", 8'h5A, 1'b1);

    // stale ack in IDLE
    loop    = 1'b0;
    ack_man = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("stale rise_ready_c%0d", i), 32'(bus.in_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("stale busy_c%0d", i), 32'(bus.busy), 32'd0);
      check($sformatf("stale req_c%0d", i), 32'(bus.req), 32'd0);
      check($sformatf("stale data_c%0d", i), 32'(bus.data_out), 32'h5A);
    end
    bus.in_valid = 1'b0;
    ack_man      = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("stale fall_ready_c%0d", i), 32'(bus.in_ready), (i == 3) ? 32'd1 : 32'd0);
    end

    // reset in the middle of REQ_HIGH
    loop         = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    step();
    bus.in_valid = 1'b0;
    check("midrst accept_data", 32'(bus.data_out), 32'h77);
    step();
    check("midrst still_req", 32'(bus.req), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst ready_in_rst", 32'(bus.in_ready), 32'd0);
    step();
    check("midrst req", 32'(bus.req), 32'd0);
    check("midrst data", 32'(bus.data_out), 32'h00);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst err", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst ready_after", 32'(bus.in_ready), 32'd1);
    xfer("after_rst", 8'h42, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
